// File: rtl/adc_frame_deserializer.sv
// Codec ADC frame deserializer: oversamples BCLK/ADCLRCK/ADCDAT in the CLK domain and
// assembles left/right words (left-justified or I2S), flagging short channel slots.

module adc_frame_deserializer #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned I2S_MODE     = 0,
    parameter logic        LEFT_LEVEL   = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    BCLK,
    input  logic                    ADCLRCK,
    input  logic                    ADCDAT,
    output logic [SAMPLE_WIDTH-1:0] leftSample,
    output logic [SAMPLE_WIDTH-1:0] rightSample,
    output logic                    sampleValid,
    output logic                    frameError,
    output logic                    locked
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLE_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    logic bclk_meta_q, bclk_meta_d;
    logic bclk_sync_q, bclk_sync_d;
    logic bclk_hist_q, bclk_hist_d;
    logic lrck_meta_q, lrck_meta_d;
    logic lrck_sync_q, lrck_sync_d;
    logic dat_meta_q, dat_meta_d;
    logic dat_sync_q, dat_sync_d;

    logic lrck_level_q, lrck_level_d;
    logic lrck_primed_q, lrck_primed_d;

    state_t state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_WIDTH-1:0] left_shift_q, left_shift_d;
    logic [SAMPLE_WIDTH-1:0] right_shift_q, right_shift_d;
    logic [SAMPLE_WIDTH-1:0] left_sample_q, left_sample_d;
    logic [SAMPLE_WIDTH-1:0] right_sample_q, right_sample_d;

    logic frame_done_q, frame_done_d;
    logic sample_valid_q, sample_valid_d;
    logic frame_error_q, frame_error_d;
    logic locked_q, locked_d;

    logic bclk_rise;
    logic lrck_change;
    logic into_left;
    logic enter_channel;
    logic capture_bit;
    logic shift_in;

    always_comb begin
        bclk_meta_d    = BCLK;
        bclk_sync_d    = bclk_meta_q;
        bclk_hist_d    = bclk_sync_q;
        lrck_meta_d    = ADCLRCK;
        lrck_sync_d    = lrck_meta_q;
        dat_meta_d     = ADCDAT;
        dat_sync_d     = dat_meta_q;

        lrck_level_d   = lrck_level_q;
        lrck_primed_d  = lrck_primed_q;
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        left_shift_d   = left_shift_q;
        right_shift_d  = right_shift_q;
        left_sample_d  = left_sample_q;
        right_sample_d = right_sample_q;
        frame_done_d   = 1'b0;
        sample_valid_d = 1'b0;
        frame_error_d  = 1'b0;
        locked_d       = locked_q;

        enter_channel  = 1'b0;
        capture_bit    = 1'b0;
        shift_in       = 1'b0;

        bclk_rise   = bclk_sync_q & ~bclk_hist_q;
        // The first rise after reset only records the level; no stored level exists yet.
        lrck_change = lrck_primed_q && (lrck_sync_q != lrck_level_q);
        into_left   = (lrck_sync_q == LEFT_LEVEL);

        if (frame_done_q) begin
            left_sample_d  = left_shift_q;
            right_sample_d = right_shift_q;
            sample_valid_d = 1'b1;
            locked_d       = 1'b1;
        end

        if (bclk_rise) begin
            lrck_level_d  = lrck_sync_q;
            lrck_primed_d = 1'b1;

            unique case (state_q)
                ST_SYNC: begin
                    if (lrck_change && into_left) begin
                        state_d       = ST_LEFT;
                        enter_channel = 1'b1;
                    end
                end
                ST_LEFT, ST_RIGHT: begin
                    if (lrck_change) begin
                        if (bit_cnt_q < CNT_FULL) begin
                            // Short slot: an edge into the left level restarts a frame at once.
                            frame_error_d = 1'b1;
                            locked_d      = 1'b0;
                            state_d       = into_left ? ST_LEFT : ST_SYNC;
                            enter_channel = into_left;
                        end else begin
                            state_d       = (state_q == ST_LEFT) ? ST_RIGHT : ST_LEFT;
                            enter_channel = 1'b1;
                        end
                    end else begin
                        capture_bit = (bit_cnt_q < CNT_FULL);
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                end
            endcase
        end

        if (enter_channel) begin
            if (I2S_MODE != 0) begin
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = CNT_W'(1);
                shift_in  = 1'b1;
            end
        end

        if (capture_bit) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            shift_in  = 1'b1;
            if ((state_q == ST_RIGHT) && (bit_cnt_q == CNT_LAST)) begin
                frame_done_d = 1'b1;
            end
        end

        if (shift_in) begin
            if (state_d == ST_LEFT) begin
                left_shift_d = {left_shift_q[SAMPLE_WIDTH-2:0], dat_sync_q};
            end else if (state_d == ST_RIGHT) begin
                right_shift_d = {right_shift_q[SAMPLE_WIDTH-2:0], dat_sync_q};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bclk_meta_q    <= 1'b0;
            bclk_sync_q    <= 1'b0;
            bclk_hist_q    <= 1'b0;
            lrck_meta_q    <= 1'b0;
            lrck_sync_q    <= 1'b0;
            dat_meta_q     <= 1'b0;
            dat_sync_q     <= 1'b0;
            lrck_level_q   <= 1'b0;
            lrck_primed_q  <= 1'b0;
            state_q        <= ST_SYNC;
            bit_cnt_q      <= '0;
            left_shift_q   <= '0;
            right_shift_q  <= '0;
            left_sample_q  <= '0;
            right_sample_q <= '0;
            frame_done_q   <= 1'b0;
            sample_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            bclk_meta_q    <= bclk_meta_d;
            bclk_sync_q    <= bclk_sync_d;
            bclk_hist_q    <= bclk_hist_d;
            lrck_meta_q    <= lrck_meta_d;
            lrck_sync_q    <= lrck_sync_d;
            dat_meta_q     <= dat_meta_d;
            dat_sync_q     <= dat_sync_d;
            lrck_level_q   <= lrck_level_d;
            lrck_primed_q  <= lrck_primed_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            left_shift_q   <= left_shift_d;
            right_shift_q  <= right_shift_d;
            left_sample_q  <= left_sample_d;
            right_sample_q <= right_sample_d;
            frame_done_q   <= frame_done_d;
            sample_valid_q <= sample_valid_d;
            frame_error_q  <= frame_error_d;
            locked_q       <= locked_d;
        end
    end

    assign leftSample  = left_sample_q;
    assign rightSample = right_sample_q;
    assign sampleValid = sample_valid_q;
    assign frameError  = frame_error_q;
    assign locked      = locked_q;

endmodule
